// File: rtl/fmps_link_pkg.sv
// Shared constants and state encoding for the FMPS link transmit/receive logic.
package fmps_link_pkg;

  localparam logic [7:0] FMPS_MAGIC = 8'hA5;

  // Header word bit positions
  localparam int HDR_MAGIC_LSB  = 24;
  localparam int HDR_SEQNO_LSB  = 16;
  localparam int HDR_ENABLE_BIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CKSUM
  } fmpsState_t;

endpackage

// File: rtl/fmps_write_link.sv
// FMPS link transmitter: formats one status packet per FA strobe onto an AXI-Stream Aurora TX port.
// Define FMPS_CHECKSUM_EN to append a negated-sum trailer word to every packet.
//
// state  | meaning
// IDLE   | no packet in flight, waiting for auFAstrobe
// HEADER | presenting the header word
// DATA   | presenting payload word wordCnt
// CKSUM  | presenting the checksum trailer (checksum build only)
module fmps_write_link
  import fmps_link_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int DATA_WORDS  = 2,
  parameter int SEQNO_WIDTH = 8
) (
  input  logic                     auClk,
  input  logic                     auResetN,
  input  logic                     auFAstrobe,
  input  logic [INDEX_WIDTH-1:0]   fmpsIndex,
  input  logic                     fmpsEnabled,
  input  logic                     fmpsInhibit,
  input  logic [32*DATA_WORDS-1:0] fmpsData,
  output logic                     TVALID,
  input  logic                     TREADY,
  output logic                     TLAST,
  output logic [31:0]              TDATA,
  output logic                     busy,
  output logic                     overrunStrobe,
  output logic                     inhibitStrobe,
  output logic [15:0]              packetCount
);

  localparam int CNT_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DATA_WORDS - 1);

  fmpsState_t state, stateNext;

  logic [CNT_W-1:0]                 wordCnt;
  logic [INDEX_WIDTH-1:0]           holdIndex;
  logic                             holdEnabled;
  logic [DATA_WORDS-1:0][31:0]      holdData;
  logic [SEQNO_WIDTH-1:0]           seqno;
  logic [31:0]                      header;
  logic                             accept;
  logic                             xfer;
  logic                             lastData;
`ifdef FMPS_CHECKSUM_EN
  logic [31:0]                      runSum;
`endif

  assign accept   = auFAstrobe && (state == IDLE) && !fmpsInhibit;
  assign busy     = (state != IDLE);
  assign TVALID   = busy;
  assign xfer     = TVALID && TREADY;
  assign lastData = (wordCnt == LAST_WORD);

  always_comb begin
    header                            = '0;
    header[HDR_MAGIC_LSB +: 8]        = FMPS_MAGIC;
    header[HDR_SEQNO_LSB +: 8]        = 8'(seqno);
    header[HDR_ENABLE_BIT]            = holdEnabled;
    header[INDEX_WIDTH-1:0]           = holdIndex;
  end

  always_ff @(posedge auClk or negedge auResetN) begin
    if (!auResetN) state <= IDLE;
    else           state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    TDATA     = '0;
    TLAST     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) stateNext = HEADER;
      end
      HEADER: begin
        TDATA = header;
        if (xfer) stateNext = DATA;
      end
      DATA: begin
        TDATA = holdData[wordCnt];
`ifdef FMPS_CHECKSUM_EN
        if (xfer && lastData) stateNext = CKSUM;
`else
        TLAST = lastData;
        if (xfer && lastData) stateNext = IDLE;
`endif
      end
      CKSUM: begin
`ifdef FMPS_CHECKSUM_EN
        TDATA = -runSum;
        TLAST = 1'b1;
        if (xfer) stateNext = IDLE;
`else
        stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge auClk or negedge auResetN) begin
    if (!auResetN) begin
      wordCnt       <= '0;
      holdIndex     <= '0;
      holdEnabled   <= 1'b0;
      holdData      <= '0;
      seqno         <= '0;
      packetCount   <= '0;
      overrunStrobe <= 1'b0;
      inhibitStrobe <= 1'b0;
`ifdef FMPS_CHECKSUM_EN
      runSum        <= '0;
`endif
    end else begin
      overrunStrobe <= auFAstrobe && busy;
      inhibitStrobe <= auFAstrobe && !busy && fmpsInhibit;
      // Snapshot inputs so later changes cannot corrupt the packet in flight
      if (accept) begin
        holdIndex   <= fmpsIndex;
        holdEnabled <= fmpsEnabled;
        holdData    <= fmpsData;
        wordCnt     <= '0;
      end else if ((state == DATA) && xfer) begin
        wordCnt <= wordCnt + CNT_W'(1);
      end
      if (xfer && TLAST) begin
        packetCount <= packetCount + 16'd1;
        seqno       <= seqno + SEQNO_WIDTH'(1);
      end
`ifdef FMPS_CHECKSUM_EN
      if (accept)                          runSum <= '0;
      else if (xfer && (state != CKSUM))   runSum <= runSum + TDATA;
`endif
    end
  end

endmodule

// File: tb/tb_fmps_write_link.sv
// Directed self-checking bench for fmps_write_link (default and FMPS_CHECKSUM_EN builds).
module tb_fmps_write_link;

  localparam int IW = 5;
  localparam int DW = 2;
  localparam int SW = 8;
`ifdef FMPS_CHECKSUM_EN
  localparam int PKT_LEN = DW + 2;
`else
  localparam int PKT_LEN = DW + 1;
`endif

  logic          auClk = 1'b0;
  logic          auResetN;
  logic          auFAstrobe;
  logic [IW-1:0] fmpsIndex;
  logic          fmpsEnabled;
  logic          fmpsInhibit;
  logic [63:0]   fmpsData;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic [31:0]   TDATA;
  logic          busy;
  logic          overrunStrobe;
  logic          inhibitStrobe;
  logic [15:0]   packetCount;

  int          nTests = 0;
  int          nFail  = 0;
  logic [7:0]  expSeq;
  logic [15:0] expCount;

  fmps_write_link #(.INDEX_WIDTH(IW), .DATA_WORDS(DW), .SEQNO_WIDTH(SW)) dut (
    .auClk(auClk), .auResetN(auResetN), .auFAstrobe(auFAstrobe),
    .fmpsIndex(fmpsIndex), .fmpsEnabled(fmpsEnabled), .fmpsInhibit(fmpsInhibit),
    .fmpsData(fmpsData), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST),
    .TDATA(TDATA), .busy(busy), .overrunStrobe(overrunStrobe),
    .inhibitStrobe(inhibitStrobe), .packetCount(packetCount)
  );

  always #5 auClk = ~auClk;

  function automatic logic [31:0] hdr(input logic [7:0] s, input logic en, input logic [4:0] idx);
    return {8'hA5, s, en, 10'b0, idx};
  endfunction

  task automatic tick();
    @(posedge auClk);
    #1;
  endtask

  task automatic strobePkt(input logic [4:0] idx, input logic en, input logic [63:0] d);
    fmpsIndex   = idx;
    fmpsEnabled = en;
    fmpsData    = d;
    fmpsInhibit = 1'b0;
    auFAstrobe  = 1'b1;
    tick();
    auFAstrobe  = 1'b0;
  endtask

  task automatic drain();
    TREADY = 1'b1;
    for (int i = 0; i < 20 && TVALID; i++) tick();
  endtask

  task automatic test_reset();
    auResetN = 1'b0; auFAstrobe = 0; fmpsIndex = '0; fmpsEnabled = 0;
    fmpsInhibit = 0; fmpsData = '0; TREADY = 1'b1;
    #12;
    nTests++;
    if ({TVALID, TLAST, busy, overrunStrobe, inhibitStrobe} !== 5'b0) begin
      nFail++; $display("FAIL reset_flags: got %b want 00000", {TVALID, TLAST, busy, overrunStrobe, inhibitStrobe});
    end
    nTests++;
    if (TDATA !== 32'h0) begin nFail++; $display("FAIL reset_tdata: got %h want 0", TDATA); end
    nTests++;
    if (packetCount !== 16'h0) begin nFail++; $display("FAIL reset_count: got %h want 0", packetCount); end
    @(negedge auClk);
    auResetN = 1'b1;
    tick();
    expSeq = 8'h00; expCount = 16'h0;
  endtask

  task automatic test_basic();
    logic [31:0] exp [4];
    logic [31:0] sum;
    exp[0] = hdr(expSeq, 1'b1, 5'd7);
    exp[1] = 32'h1111_1111;
    exp[2] = 32'h2222_2222;
    exp[3] = 32'h27CC_4CC6;
    sum = '0;
    TREADY = 1'b1;
    strobePkt(5'd7, 1'b1, {32'h2222_2222, 32'h1111_1111});
    fmpsData = '1;
    for (int i = 0; i < PKT_LEN; i++) begin
      nTests++;
      if (TVALID !== 1'b1 || TDATA !== exp[i] || TLAST !== (i == PKT_LEN - 1)) begin
        nFail++;
        $display("FAIL basic_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, TVALID, TDATA, TLAST, exp[i], (i == PKT_LEN - 1));
      end
      sum = sum + TDATA;
      tick();
    end
`ifdef FMPS_CHECKSUM_EN
    nTests++;
    if (sum !== 32'h0) begin nFail++; $display("FAIL basic_sum: got %h want 0", sum); end
`endif
    nTests++;
    if (TVALID !== 1'b0 || busy !== 1'b0) begin
      nFail++; $display("FAIL basic_idle: got v=%b busy=%b want 0 0", TVALID, busy);
    end
    expSeq++; expCount++;
    nTests++;
    if (packetCount !== expCount) begin nFail++; $display("FAIL basic_count: got %h want %h", packetCount, expCount); end
  endtask

  task automatic test_stall();
    logic [31:0] exp [4];
    logic [31:0] obs [4];
    logic [31:0] prevData;
    logic        prevLast, prevStall, rdy;
    int          nObs, lastPos;
    exp[0] = hdr(expSeq, 1'b1, 5'd7);
    exp[1] = 32'h1111_1111;
    exp[2] = 32'h2222_2222;
    exp[3] = -(exp[0] + exp[1] + exp[2]);
    nObs = 0; lastPos = -1; prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
    strobePkt(5'd7, 1'b1, {32'h2222_2222, 32'h1111_1111});
    for (int cyc = 0; cyc < 40 && nObs < PKT_LEN; cyc++) begin
      rdy = (cyc % 2 == 1);
      nTests++;
      if (TVALID !== 1'b1) begin nFail++; $display("FAIL stall_valid: got %b want 1 at cycle %0d", TVALID, cyc); end
      if (prevStall) begin
        nTests++;
        if (TDATA !== prevData || TLAST !== prevLast) begin
          nFail++; $display("FAIL stall_stable: got d=%h l=%b want d=%h l=%b", TDATA, TLAST, prevData, prevLast);
        end
      end
      TREADY = rdy;
      if (TVALID && rdy) begin
        obs[nObs] = TDATA;
        if (TLAST) lastPos = nObs;
        nObs++;
      end
      prevStall = TVALID && !rdy;
      prevData  = TDATA;
      prevLast  = TLAST;
      tick();
    end
    TREADY = 1'b1;
    nTests++;
    if (nObs !== PKT_LEN) begin nFail++; $display("FAIL stall_len: got %0d want %0d", nObs, PKT_LEN); end
    for (int i = 0; i < PKT_LEN && i < nObs; i++) begin
      nTests++;
      if (obs[i] !== exp[i]) begin nFail++; $display("FAIL stall_word%0d: got %h want %h", i, obs[i], exp[i]); end
    end
    nTests++;
    if (lastPos !== PKT_LEN - 1) begin nFail++; $display("FAIL stall_tlast: got pos %0d want %0d", lastPos, PKT_LEN - 1); end
    expSeq++; expCount++;
    nTests++;
    if (TVALID !== 1'b0 || packetCount !== expCount) begin
      nFail++; $display("FAIL stall_end: got v=%b cnt=%h want v=0 cnt=%h", TVALID, packetCount, expCount);
    end
  endtask

  task automatic test_overrun();
    TREADY = 1'b1;
    strobePkt(5'd3, 1'b1, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
    tick();
    auFAstrobe = 1'b1;
    tick();
    auFAstrobe = 1'b0;
    nTests++;
    if (overrunStrobe !== 1'b1 || TDATA !== 32'hBBBB_BBBB) begin
      nFail++; $display("FAIL overrun_pulse: got o=%b d=%h want o=1 d=bbbbbbbb", overrunStrobe, TDATA);
    end
    tick();
    nTests++;
    if (overrunStrobe !== 1'b0) begin nFail++; $display("FAIL overrun_once: got %b want 0", overrunStrobe); end
    drain();
    tick(); tick();
    expSeq++; expCount++;
    nTests++;
    if (TVALID !== 1'b0 || packetCount !== expCount) begin
      nFail++; $display("FAIL overrun_single: got v=%b cnt=%h want v=0 cnt=%h", TVALID, packetCount, expCount);
    end
  endtask

  task automatic test_inhibit();
    TREADY = 1'b1;
    fmpsInhibit = 1'b1;
    auFAstrobe  = 1'b1;
    tick();
    auFAstrobe  = 1'b0;
    fmpsInhibit = 1'b0;
    nTests++;
    if (TVALID !== 1'b0 || inhibitStrobe !== 1'b1) begin
      nFail++; $display("FAIL inhibit_pulse: got v=%b i=%b want v=0 i=1", TVALID, inhibitStrobe);
    end
    tick();
    nTests++;
    if (TVALID !== 1'b0 || inhibitStrobe !== 1'b0) begin
      nFail++; $display("FAIL inhibit_clear: got v=%b i=%b want 0 0", TVALID, inhibitStrobe);
    end
    strobePkt(5'd31, 1'b0, {32'h0, 32'h0});
    nTests++;
    if (TDATA !== hdr(expSeq, 1'b0, 5'd31)) begin
      nFail++; $display("FAIL inhibit_seq: got %h want %h", TDATA, hdr(expSeq, 1'b0, 5'd31));
    end
    drain();
    expSeq++; expCount++;
    nTests++;
    if (packetCount !== expCount) begin nFail++; $display("FAIL inhibit_count: got %h want %h", packetCount, expCount); end
  endtask

  task automatic test_back_to_back();
    TREADY = 1'b1;
    strobePkt(5'd9, 1'b1, {32'h0000_0002, 32'h0000_0001});
    for (int i = 0; i < PKT_LEN - 1; i++) tick();
    nTests++;
    if (TLAST !== 1'b1) begin nFail++; $display("FAIL b2b_last: got %b want 1", TLAST); end
    auFAstrobe = 1'b1;
    tick();
    nTests++;
    if (overrunStrobe !== 1'b1 || TVALID !== 1'b0) begin
      nFail++; $display("FAIL b2b_final_strobe: got o=%b v=%b want o=1 v=0", overrunStrobe, TVALID);
    end
    expSeq++; expCount++;
    tick();
    auFAstrobe = 1'b0;
    nTests++;
    if (TVALID !== 1'b1 || TDATA !== hdr(expSeq, 1'b1, 5'd9)) begin
      nFail++; $display("FAIL b2b_accept: got v=%b d=%h want v=1 d=%h", TVALID, TDATA, hdr(expSeq, 1'b1, 5'd9));
    end
    drain();
    expSeq++; expCount++;
    nTests++;
    if (packetCount !== expCount) begin nFail++; $display("FAIL b2b_count: got %h want %h", packetCount, expCount); end
  endtask

  task automatic test_seqno_wrap();
    TREADY = 1'b1;
    for (int k = 0; k < 300 && expSeq != 8'hFF; k++) begin
      strobePkt(5'd1, 1'b1, 64'h0);
      nTests++;
      if (TDATA !== hdr(expSeq, 1'b1, 5'd1)) begin
        nFail++; $display("FAIL wrap_hdr: got %h want %h", TDATA, hdr(expSeq, 1'b1, 5'd1));
      end
      drain();
      expSeq++; expCount++;
    end
    strobePkt(5'd1, 1'b1, 64'h0);
    nTests++;
    if (TDATA !== 32'hA5FF_8001) begin nFail++; $display("FAIL wrap_ff: got %h want a5ff8001", TDATA); end
    drain();
    expSeq++; expCount++;
    strobePkt(5'd1, 1'b1, 64'h0);
    nTests++;
    if (TDATA !== 32'hA500_8001) begin nFail++; $display("FAIL wrap_00: got %h want a5008001", TDATA); end
    drain();
    expSeq++; expCount++;
    nTests++;
    if (packetCount !== expCount) begin nFail++; $display("FAIL wrap_count: got %h want %h", packetCount, expCount); end
  endtask

  task automatic test_reset_mid();
    TREADY = 1'b1;
    strobePkt(5'd7, 1'b1, {32'h2222_2222, 32'h1111_1111});
    tick();
    TREADY = 1'b0;
    tick();
    nTests++;
    if (TVALID !== 1'b1 || TDATA !== 32'h1111_1111) begin
      nFail++; $display("FAIL rstmid_stall: got v=%b d=%h want v=1 d=11111111", TVALID, TDATA);
    end
    #2;
    auResetN = 1'b0;
    #1;
    nTests++;
    if (TVALID !== 1'b0 || TLAST !== 1'b0 || busy !== 1'b0 || packetCount !== 16'h0) begin
      nFail++; $display("FAIL rstmid_drop: got v=%b l=%b b=%b cnt=%h want 0 0 0 0", TVALID, TLAST, busy, packetCount);
    end
    @(negedge auClk);
    auResetN = 1'b1;
    TREADY = 1'b1;
    tick();
    expSeq = 8'h00; expCount = 16'h0;
    strobePkt(5'd2, 1'b1, 64'h0);
    nTests++;
    if (TDATA !== hdr(8'h00, 1'b1, 5'd2)) begin
      nFail++; $display("FAIL rstmid_seq: got %h want %h", TDATA, hdr(8'h00, 1'b1, 5'd2));
    end
    drain();
    expCount++;
    nTests++;
    if (packetCount !== expCount) begin nFail++; $display("FAIL rstmid_count: got %h want %h", packetCount, expCount); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_inhibit();
    test_back_to_back();
    test_seqno_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
